// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants for the gshare branch history table: counter encodings,
// the reset counter value and the conditional-branch opcode.
package branch_predictor_bht_pkg;
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_WT    = 2'b10;
    localparam logic [1:0] CTR_ST    = 2'b11;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
endpackage

// File: rtl/branch_predictor_bht_sat_counter2.sv
// Two-bit saturating up/down counter; one instance per table entry.
module sat_counter2
    import branch_predictor_bht_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    output logic [1:0] count
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CTR_RESET;
        end else if (en) begin
            if (up && count != CTR_ST) begin
                count <= count + 2'd1;
            end else if (!up && count != CTR_SNT) begin
                count <= count - 2'd1;
            end
        end
    end
endmodule

// File: rtl/branch_predictor_bht.sv
// Gshare branch predictor: PC bits XOR global history select a 2-bit counter;
// counters, history and statistics train non-speculatively at resolve.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [31:0]           lookup_pc,
    output logic                  predict_taken,
    output logic [INDEX_BITS-1:0] predict_index,
    input  logic                  resolve_valid,
    input  logic [INDEX_BITS-1:0] resolve_index,
    input  logic                  resolve_taken,
    input  logic                  resolve_predicted,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    // Valid-only qualification: there is no ready/backpressure. A lookup is
    // never stalled and never changes state; a resolve is consumed on every
    // clock edge where resolve_valid is high and reset is low.
    logic [1:0]            ctr [ENTRIES];
    logic [INDEX_BITS-1:0] ghr;
    logic                  resolve_wrong;
    logic                  unused_lookup;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        sat_counter2 u_ctr (
            .clk   (clk),
            .reset (reset),
            .en    (resolve_valid && (resolve_index == INDEX_BITS'(i))),
            .up    (resolve_taken),
            .count (ctr[i])
        );
    end

    // Prediction reads pre-update state; no bypass from a same-cycle resolve.
    assign predict_index = lookup_pc[INDEX_BITS+1:2] ^ ghr;
    assign predict_taken = ctr[predict_index][1];
    assign resolve_wrong = resolve_valid && (resolve_taken != resolve_predicted);
    assign unused_lookup = ^{lookup_valid, lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr              <= '0;
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= resolve_wrong;
            if (resolve_valid) begin
                ghr <= {ghr[INDEX_BITS-2:0], resolve_taken};
                if (branch_count != '1) begin
                    branch_count <= branch_count + STAT_WIDTH'(1);
                end
            end
            // Statistics saturate so long board runs never wrap to small values.
            if (resolve_wrong && mispredict_count != '1) begin
                mispredict_count <= mispredict_count + STAT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed table-driven bench for the gshare BHT (INDEX_BITS=4, STAT_WIDTH=4).
module tb_branch_predictor_bht;
    localparam int IB = 4;
    localparam int SW = 4;

    logic          clk;
    logic          reset;
    logic          lookup_valid;
    logic [31:0]   lookup_pc;
    logic          predict_taken;
    logic [IB-1:0] predict_index;
    logic          resolve_valid;
    logic [IB-1:0] resolve_index;
    logic          resolve_taken;
    logic          resolve_predicted;
    logic          mispredict;
    logic [SW-1:0] branch_count;
    logic [SW-1:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0]   pc;
        logic          rv;
        logic [IB-1:0] ri;
        logic          rt;
        logic          rp;
        logic          exp_pt;
        logic [IB-1:0] exp_pi;
        logic          exp_mis;
        logic [SW-1:0] exp_bc;
        logic [SW-1:0] exp_mc;
    } vec_t;

    vec_t vecs[$];

    branch_predictor_bht #(.INDEX_BITS(IB), .STAT_WIDTH(SW)) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .predict_taken     (predict_taken),
        .predict_index     (predict_index),
        .resolve_valid     (resolve_valid),
        .resolve_index     (resolve_index),
        .resolve_taken     (resolve_taken),
        .resolve_predicted (resolve_predicted),
        .mispredict        (mispredict),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic add_vec(input logic [31:0] pc, input logic rv, input logic [IB-1:0] ri,
                           input logic rt, input logic rp, input logic pt, input logic [IB-1:0] pi,
                           input logic mis, input logic [SW-1:0] bc, input logic [SW-1:0] mc);
        vec_t v;
        v = '{pc: pc, rv: rv, ri: ri, rt: rt, rp: rp, exp_pt: pt, exp_pi: pi,
              exp_mis: mis, exp_bc: bc, exp_mc: mc};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] pc, input logic rv, input logic [IB-1:0] ri,
                         input logic rt, input logic rp);
        lookup_valid      = 1'b1;
        lookup_pc         = pc;
        resolve_valid     = rv;
        resolve_index     = ri;
        resolve_taken     = rt;
        resolve_predicted = rp;
    endtask

    task automatic check_stats(input string tag, input logic mis, input logic [SW-1:0] bc,
                               input logic [SW-1:0] mc);
        check({tag, "_mispredict"}, 32'(mispredict), 32'(mis));
        check({tag, "_branch_count"}, 32'(branch_count), 32'(bc));
        check({tag, "_mispredict_count"}, 32'(mispredict_count), 32'(mc));
    endtask

    initial begin
        // Hand-traced: GHR and counter values noted after each resolve.
        add_vec(32'h100, 1, 4'h0, 1, 0, 0, 4'h0, 1, 4'd1, 4'd1);  // c0=10 ghr=0001
        add_vec(32'h100, 1, 4'h1, 1, 0, 0, 4'h1, 1, 4'd2, 4'd2);  // c1=10 ghr=0011
        add_vec(32'h100, 1, 4'h3, 1, 0, 0, 4'h3, 1, 4'd3, 4'd3);  // c3=10 ghr=0111
        add_vec(32'h01C, 0, 4'h0, 0, 0, 1, 4'h0, 0, 4'd3, 4'd3);  // c0 reads 10
        add_vec(32'h01C, 1, 4'h5, 0, 0, 1, 4'h0, 0, 4'd4, 4'd3);  // c5=00 ghr=1110
        add_vec(32'h01C, 1, 4'h5, 1, 0, 0, 4'h9, 1, 4'd5, 4'd4);  // c5=01 ghr=1101
        add_vec(32'h01C, 1, 4'h5, 0, 1, 0, 4'hA, 1, 4'd6, 4'd5);  // c5=00 ghr=1010
        add_vec(32'h01C, 1, 4'h6, 1, 1, 0, 4'hD, 0, 4'd7, 4'd5);  // c6=10 ghr=0101
        add_vec(32'h03C, 0, 4'h0, 0, 0, 0, 4'hA, 0, 4'd7, 4'd5);  // 0xF^0x5=0xA
        add_vec(32'h03C, 1, 4'h5, 0, 0, 0, 4'hA, 0, 4'd8, 4'd5);  // c5 stays 00 ghr=1010
        add_vec(32'h03C, 0, 4'h0, 0, 0, 0, 4'h5, 0, 4'd8, 4'd5);  // c5 reads 00
        add_vec(32'h03C, 1, 4'h0, 1, 1, 0, 4'h5, 0, 4'd9, 4'd5);  // c0=11 ghr=0101
        add_vec(32'h03C, 1, 4'h0, 1, 1, 0, 4'hA, 0, 4'd10, 4'd5); // c0 stays 11 ghr=1011
        add_vec(32'h03C, 1, 4'h0, 0, 1, 0, 4'h4, 1, 4'd11, 4'd6); // c0=10 ghr=0110
        add_vec(32'h018, 0, 4'h0, 0, 0, 1, 4'h0, 0, 4'd11, 4'd6); // c0 reads 10
        add_vec(32'h010, 1, 4'h2, 1, 0, 0, 4'h2, 1, 4'd12, 4'd7); // same-cycle: pre-update 01
        add_vec(32'h03C, 0, 4'h0, 0, 0, 1, 4'h2, 0, 4'd12, 4'd7); // c2 reads 10, ghr=1101
        add_vec(32'h03C, 1, 4'h7, 0, 1, 1, 4'h2, 1, 4'd13, 4'd8); // ghr=1010
        add_vec(32'h03C, 1, 4'h7, 0, 1, 0, 4'h5, 1, 4'd14, 4'd9); // ghr=0100
        add_vec(32'h03C, 0, 4'h0, 0, 0, 0, 4'hB, 0, 4'd14, 4'd9);

        reset = 1'b1;
        drive(32'h100, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_predict_taken", 32'(predict_taken), 32'd0);
        check("reset_predict_index", 32'(predict_index), 32'h0);
        check_stats("reset", 0, 4'd0, 4'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].rv, vecs[i].ri, vecs[i].rt, vecs[i].rp);
            #1;
            check($sformatf("v%0d_predict_taken", i), 32'(predict_taken), 32'(vecs[i].exp_pt));
            check($sformatf("v%0d_predict_index", i), 32'(predict_index), 32'(vecs[i].exp_pi));
            @(posedge clk);
            #1;
            check_stats($sformatf("v%0d", i), vecs[i].exp_mis, vecs[i].exp_bc, vecs[i].exp_mc);
        end

        // Six more mispredicted resolves: both statistics counters reach 0xF and hold.
        for (int k = 1; k <= 6; k++) begin
            drive(32'h03C, 1, 4'h8, 0, 1);
            @(posedge clk);
            #1;
            check_stats($sformatf("sat%0d", k), 1, (14 + k > 15) ? 4'hF : SW'(14 + k),
                        (9 + k > 15) ? 4'hF : SW'(9 + k));
        end

        // Async reset mid-run, away from any edge; a same-cycle resolve to c6 is dropped.
        drive(32'h018, 1, 4'h6, 1, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_predict_index", 32'(predict_index), 32'h6);
        check("async_predict_taken", 32'(predict_taken), 32'd0);
        check_stats("async", 0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(32'h018, 0, '0, 0, 0);
        #1;
        check("post_reset_c6", 32'(predict_taken), 32'd0);
        @(posedge clk);
        #1;
        check_stats("post_reset", 0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Two-bit saturating-counter branch history table with global-history (gshare) indexing. Sits beside the ALU in the processor pipeline. At fetch it predicts conditional branches. It consumes the ALU's `Branch_Enable` result, qualified by the pipeline, to train its counters and flag mispredictions back to the fetch/flush logic. It also keeps saturating statistics counters for performance measurement on the board.

## Interface
Parameters:
- `INDEX_BITS`, 4: log2 of table entries; also the global history register (GHR) width.
- `STAT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `lookup_valid` in 1: a fetched instruction is a conditional branch (opcode 1100011).
- `lookup_pc` in 32: PC of that branch.
- `predict_taken` out 1: combinational prediction for the current lookup.
- `predict_index` out INDEX_BITS: combinational table index used; pipeline carries it to resolve.
- `resolve_valid` in 1: branch resolved in EX this cycle.
- `resolve_index` in INDEX_BITS: `predict_index` captured at lookup.
- `resolve_taken` in 1: ALU `Branch_Enable`.
- `resolve_predicted` in 1: `predict_taken` captured at lookup.
- `mispredict` out 1: registered; high for one cycle after a mispredicted resolve.
- `branch_count` out STAT_WIDTH: resolved branches.
- `mispredict_count` out STAT_WIDTH: mispredicted branches.

## Operation
- Table: 2^INDEX_BITS entries of 2-bit counters.
  - Encoding: 00 strongly-not-taken (SNT), 01 weakly-not-taken (WNT), 10 weakly-taken (WT), 11 strongly-taken (ST).
- Index: `lookup_pc[INDEX_BITS+1:2] ^ ghr`.
- `predict_taken` = MSB of the indexed counter.
- `predict_taken` and `predict_index` are driven regardless of `lookup_valid`; consumers qualify them.
- On `resolve_valid`, counter at `resolve_index` updates:
  - taken: increment, saturating at 11.
  - not taken: decrement, saturating at 00.
- GHR is updated at resolve only (non-speculative): `ghr <= {ghr[INDEX_BITS-2:0], resolve_taken}`.
- `mispredict <= resolve_valid & (resolve_taken != resolve_predicted)`.
- `branch_count` increments on each `resolve_valid`.
- `mispredict_count` increments on each mispredicted resolve.
- Both statistics counters saturate at all-ones; they never wrap.
- `lookup_valid` has no effect on state; the table is read-only at lookup.

## Timing
- Reset (async assert, synchronous-to-clk release):
  - all counters = 01 (WNT).
  - `ghr` = 0.
  - `mispredict` = 0.
  - both statistics counters = 0.
- Reset mid-operation clears everything immediately. A resolve in the same cycle as reset is discarded.
- Prediction latency 0: combinational from `lookup_pc` and current state.
- Update latency 1: counter, GHR and statistics take new values at the edge ending the resolve cycle.
- `mispredict` is valid the cycle after resolve and lasts exactly one cycle per mispredicted resolve. Back-to-back mispredicted resolves hold it high continuously.
- Lookup and resolve in the same cycle, same index: lookup sees the pre-update counter (no bypass). The index is computed with the pre-update GHR.
- Saturation boundaries:
  - counter at 11 + taken stays 11.
  - counter at 00 + not taken stays 00.
  - statistics counters at 2^STAT_WIDTH-1 hold.

## Structure
- Shared defines include file holds:
  - counter state constants (SNT/WNT/WT/ST).
  - the reset counter value.
  - the branch opcode constant 1100011.
- One sub-module is natural: `sat_counter2`, a 2-bit saturating up/down counter with async reset to WNT, instantiated per entry via generate.
- Statistics counters are inline.

## Test plan
- Reset, `lookup_pc`=0x100 → `predict_taken`=0, `predict_index`=0x0; both statistics counters 0; `mispredict`=0.
- Resolve index 0x0 taken three times, GHR tracked:
  - counter 0x0 goes 01→10; later-indexed entries are trained separately.
  - `branch_count`=3.
  - `mispredict` pulses for each resolve whose `resolve_predicted`=0 was wrong.
- `INDEX_BITS`=4, GHR=0b0101 after known history, `lookup_pc`=0x3C → `predict_index`=0xF^0x5=0xA.
- Simultaneous lookup and resolve (taken) at index 0x2 with counter 01 → `predict_taken`=0 that cycle, counter reads 10 next cycle.
- `resolve_predicted`=1, `resolve_taken`=0 on two consecutive cycles → `mispredict` high for two cycles starting one cycle later; `mispredict_count`=2.
- `STAT_WIDTH`=4, 20 resolves → `branch_count` saturates at 0xF.
- Reset asserted mid-run → all outputs and counters back to reset values without a clock edge.
